// File: rtl/serial_reg_master_if.sv
// Serial register bus: UART RX/TX byte streams plus register-slave strobes and data.
interface serial_reg_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_data_out,
    output tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_data_out,
    input  tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write
  );
endinterface

// File: rtl/serial_reg_master.sv
// Frame decoder driving register strobes; reg_write 1 cycle after data byte, tx_valid 1 cycle after reg_read,
// tx held until tx_ready. SERIAL_REG_ACK_EN adds an ACK_BYTE reply after every write frame.
module serial_reg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`ifdef SERIAL_REG_ACK_EN
  , parameter logic [7:0] ACK_BYTE = 8'hAC
`endif
) (
  input  logic                i_clk_usb,
  input  logic                i_reset,
  serial_reg_master_if.master bus,
  output logic                o_busy,
  output logic                o_frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CTRL     = 3'd1;
  localparam logic [2:0] S_LEN_LO   = 3'd2;
  localparam logic [2:0] S_LEN_HI   = 3'd3;
  localparam logic [2:0] S_WR_DATA  = 3'd4;
  localparam logic [2:0] S_RD_FETCH = 3'd5;
  localparam logic [2:0] S_RD_SEND  = 3'd6;
`ifdef SERIAL_REG_ACK_EN
  localparam logic [2:0] S_ACK      = 3'd7;
  localparam logic [2:0] S_WR_END   = S_ACK;
`else
  localparam logic [2:0] S_WR_END   = S_IDLE;
`endif

  logic [2:0]    r_state;
  logic [TW-1:0] r_to_cnt;
  logic          r_rd;
  logic [15:0]   r_len;
  logic [7:0]    r_cmd;
  logic [15:0]   r_bytecount;
  logic [7:0]    r_data_in;
  logic          r_read;
  logic          r_write;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_frame_error;

  logic [15:0]   w_len_full;
  logic [15:0]   w_wr_idx;
  logic          w_rd_last;
  logic          w_timing;
  logic          w_timeout;

  assign w_len_full = {bus.rx_data, r_len[7:0]};
  // A write strobe still pending means its bytecount bump lands this same edge.
  assign w_wr_idx   = r_bytecount + {15'd0, r_write};
  assign w_rd_last  = (r_bytecount == r_len - 16'd1);
  assign w_timing   = (r_state == S_CTRL) || (r_state == S_LEN_LO) ||
                      (r_state == S_LEN_HI) || (r_state == S_WR_DATA);
  assign w_timeout  = w_timing && !bus.rx_valid && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk_usb or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_rd          <= 1'b0;
      r_len         <= '0;
      r_cmd         <= '0;
      r_bytecount   <= '0;
      r_data_in     <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_write       <= 1'b0;
      r_frame_error <= 1'b0;
      r_to_cnt      <= w_timing ? r_to_cnt + 1'b1 : '0;
      if (r_write && r_state == S_WR_DATA) r_bytecount <= r_bytecount + 16'd1;

      case (r_state)
        S_IDLE: if (bus.rx_valid) begin
          r_cmd    <= bus.rx_data;
          r_to_cnt <= '0;
          r_state  <= S_CTRL;
        end
        S_CTRL: if (bus.rx_valid) begin
          r_rd     <= bus.rx_data[0];
          r_to_cnt <= '0;
          r_state  <= S_LEN_LO;
        end
        S_LEN_LO: if (bus.rx_valid) begin
          r_len[7:0] <= bus.rx_data;
          r_to_cnt   <= '0;
          r_state    <= S_LEN_HI;
        end
        S_LEN_HI: if (bus.rx_valid) begin
          r_len       <= w_len_full;
          r_bytecount <= '0;
          r_to_cnt    <= '0;
          if (w_len_full == 16'd0) begin
            r_state <= r_rd ? S_IDLE : S_WR_END;
`ifdef SERIAL_REG_ACK_EN
            if (!r_rd) begin
              r_tx_data  <= ACK_BYTE;
              r_tx_valid <= 1'b1;
            end
`endif
          end else if (r_rd) begin
            r_read  <= 1'b1;
            r_state <= S_RD_FETCH;
          end else begin
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: if (bus.rx_valid) begin
          r_data_in <= bus.rx_data;
          r_write   <= 1'b1;
          r_to_cnt  <= '0;
          if (w_wr_idx == r_len - 16'd1) begin
            r_state <= S_WR_END;
`ifdef SERIAL_REG_ACK_EN
            r_tx_data  <= ACK_BYTE;
            r_tx_valid <= 1'b1;
`endif
          end
        end
        S_RD_FETCH: begin
          r_read     <= 1'b0;
          r_tx_data  <= bus.reg_data_out;
          r_tx_valid <= 1'b1;
          r_state    <= S_RD_SEND;
        end
        S_RD_SEND: if (bus.tx_ready) begin
          r_tx_valid <= 1'b0;
          if (w_rd_last) begin
            r_state <= S_IDLE;
          end else begin
            r_bytecount <= r_bytecount + 16'd1;
            r_read      <= 1'b1;
            r_state     <= S_RD_FETCH;
          end
        end
`ifdef SERIAL_REG_ACK_EN
        S_ACK: if (bus.tx_ready) begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_state       <= S_IDLE;
        r_frame_error <= 1'b1;
        r_to_cnt      <= '0;
      end
    end
  end

  assign bus.tx_data       = r_tx_data;
  assign bus.tx_valid      = r_tx_valid;
  assign bus.reg_cmd       = r_cmd;
  assign bus.reg_bytecount = r_bytecount;
  assign bus.reg_data_in   = r_data_in;
  assign bus.reg_read      = r_read;
  assign bus.reg_write     = r_write;
  assign o_busy            = (r_state != S_IDLE);
  assign o_frame_error     = r_frame_error;

endmodule
